// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state, read-source encoding and MMIO addresses for mem_responder.
package mem_pkg;
  localparam int CNT_W = 4;
  localparam logic [31:0] MMIO_LED_ADR = 32'hFFFF_FF00;
  localparam logic [31:0] MMIO_SW_ADR = 32'hFFFF_FF04;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_MMIO} src_e;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU memory bus, master = CPU, slave = memory responder.
interface mem_responder_if;
  logic req, we, ready, err, busy;
  logic [31:0] adr, wdata, rdata;
  modport master(output req, we, adr, wdata, input rdata, ready, err, busy);
  modport slave(input req, we, adr, wdata, output rdata, ready, err, busy);
endinterface

// File: rtl/mem_array.sv
// mem_array: single-port RAM, sync write, registered read, async debug read port.
module mem_array #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] dbg_addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic [31:0]   dbg_data
);
  logic [31:0] mem [2**AW];
  always_ff @(posedge clk) if (we) mem[addr] <= wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata <= '0;
    else if (re) rdata <= mem[addr];
  assign dbg_data = mem[dbg_addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-stated word memory responding on the CPU bus.
// Optional LED/switch MMIO registers enabled by MEM_RESPONDER_MMIO_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int WAIT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_responder_if.slave        bus,
  input  logic [DEPTH_LOG2-1:0] dbg_sel,
  output logic [31:0]           dbg_data,
  output logic [15:0]           leds,
  input  logic [15:0]           sw
);
  state_e state, state_nx;
  src_e src;
  logic [CNT_W-1:0] cnt;
  logic [DEPTH_LOG2-1:0] idx_q, a_idx;
  logic [31:0] wdata_q, ram_q;
  logic [15:0] mmio_q;
  logic we_q, fault_q, fault, mmio, a_fault, a_mmio, accept, enter_resp, commit;
  assign accept = state == ST_IDLE && bus.req;
  assign enter_resp = state != ST_RESP && state_nx == ST_RESP;
  assign commit = state == ST_RESP && we_q && !fault_q;
  // with WAIT=0 RESP is entered on the accept edge, so decode straight from the bus
  assign a_idx = state == ST_IDLE ? bus.adr[DEPTH_LOG2+1:2] : idx_q;
  assign a_fault = state == ST_IDLE ? fault : fault_q;
`ifdef MEM_RESPONDER_MMIO_EN
  logic is_led, is_sw, led_q, sw_q, a_led;
  assign is_led = bus.adr == MMIO_LED_ADR;
  assign is_sw = bus.adr == MMIO_SW_ADR;
  assign fault = |bus.adr[1:0] || (|bus.adr[31:DEPTH_LOG2+2] && !is_led && !is_sw);
  assign mmio = led_q || sw_q;
  assign a_led = state == ST_IDLE ? is_led : led_q;
  assign a_mmio = state == ST_IDLE ? is_led || is_sw : mmio;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      led_q <= 1'b0;
      sw_q <= 1'b0;
      leds <= '0;
      mmio_q <= '0;
    end else begin
      if (accept) begin
        led_q <= is_led;
        sw_q <= is_sw;
      end
      if (enter_resp) mmio_q <= a_led ? leds : sw;
      if (commit && led_q) leds <= wdata_q[15:0];
    end
`else
  logic unused_sw;
  assign unused_sw = ^sw;
  assign fault = |bus.adr[1:0] || |bus.adr[31:DEPTH_LOG2+2];
  assign mmio = 1'b0;
  assign a_mmio = 1'b0;
  assign mmio_q = '0;
  assign leds = '0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = !bus.req ? ST_IDLE : WAIT == 0 ? ST_RESP : ST_WAIT;
      ST_WAIT: state_nx = cnt == CNT_W'(1) ? ST_RESP : ST_WAIT;
      default: state_nx = ST_IDLE;
    endcase
  end
  always_comb begin
    bus.ready = state == ST_RESP;
    bus.err = state == ST_RESP && fault_q;
    bus.busy = state != ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      idx_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      fault_q <= 1'b0;
      src <= SRC_ZERO;
    end else begin
      if (accept) begin
        cnt <= CNT_W'(WAIT);
        idx_q <= bus.adr[DEPTH_LOG2+1:2];
        wdata_q <= bus.wdata;
        we_q <= bus.we;
        fault_q <= fault;
      end else if (state == ST_WAIT) cnt <= cnt - CNT_W'(1);
      if (enter_resp) src <= a_fault ? SRC_ZERO : a_mmio ? SRC_MMIO : SRC_RAM;
    end
  assign bus.rdata = src == SRC_RAM ? ram_q : src == SRC_MMIO ? {16'b0, mmio_q} : '0;
  mem_array #(.AW(DEPTH_LOG2)) u_array (
    .clk(clk),
    .rst(rst),
    .we(commit && !mmio),
    .re(enter_resp && !a_fault && !a_mmio),
    .addr(a_idx),
    .dbg_addr(dbg_sel),
    .wdata(wdata_q),
    .rdata(ram_q),
    .dbg_data(dbg_data)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks on a WAIT=2 and a WAIT=0 instance.
module tb_mem_responder;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] dsel0 = '0, dsel1 = '0;
  logic [31:0] dd0, dd1;
  logic [15:0] leds0, leds1, sw = '0;
  int n_cmp = 0, n_bad = 0;
  mem_responder_if b0(), b1();
  always #5 clk = ~clk;
  mem_responder #(.DEPTH_LOG2(8), .WAIT(2)) u0 (
    .clk(clk), .rst(rst), .bus(b0), .dbg_sel(dsel0), .dbg_data(dd0), .leds(leds0), .sw(sw));
  mem_responder #(.DEPTH_LOG2(8), .WAIT(0)) u1 (
    .clk(clk), .rst(rst), .bus(b1), .dbg_sel(dsel1), .dbg_data(dd1), .leds(leds1), .sw(sw));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      b0.req = r; b0.we = w; b0.adr = a; b0.wdata = wd;
    end else begin
      b1.req = r; b1.we = w; b1.adr = a; b1.wdata = wd;
    end
  endtask
  task automatic acc(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd, output logic er);
    drive(d, 1'b1, w, a, wd);
    @(posedge clk);
    #1 drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
    lat = 0; rd = '0; er = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if ((d == 0 ? b0.ready : b1.ready) === 1'b1) begin
        lat = k;
        rd = d == 0 ? b0.rdata : b1.rdata;
        er = d == 0 ? b0.err : b1.err;
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, rc, bc;
    logic [31:0] rd;
    logic er;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, b0.ready}, 32'd0);
    check("rst_busy", {31'b0, b0.busy}, 32'd0);
    check("rst_err", {31'b0, b0.err}, 32'd0);
    check("rst_rdata", b0.rdata, 32'h0);
    check("rst_leds", {16'b0, leds0}, 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    acc(0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, rd, er);
    check("w2_wr_lat", lat, 32'd3);
    check("w2_wr_err", {31'b0, er}, 32'd0);
    acc(0, 1'b0, 32'h10, 32'h0, lat, rd, er);
    check("w2_rd_lat", lat, 32'd3);
    check("w2_rd_data", rd, 32'hDEAD_BEEF);
    check("w2_rd_err", {31'b0, er}, 32'd0);
    dsel0 = 8'd4;
    #1 check("w2_dbg4", dd0, 32'hDEAD_BEEF);
    acc(1, 1'b1, 32'h0, 32'h1234, lat, rd, er);
    acc(1, 1'b0, 32'h0, 32'h0, lat, rd, er);
    check("w0_rd_lat", lat, 32'd1);
    check("w0_rd_data", rd, 32'h1234);
    acc(1, 1'b0, 32'h6, 32'h0, lat, rd, er);
    check("misalign_lat", lat, 32'd1);
    check("misalign_err", {31'b0, er}, 32'd1);
    check("misalign_rdata", rd, 32'h0);
    acc(1, 1'b1, 32'h400, 32'h55, lat, rd, er);
    check("oor_err", {31'b0, er}, 32'd1);
    dsel1 = 8'd0;
    #1 check("oor_dbg0", dd1, 32'h1234);
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    rc = 0; bc = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 4) b0.req = 1'b0;
      rc += int'(b0.ready);
      bc += int'(b0.busy);
    end
    check("ign_ready_cnt", rc, 32'd1);
    check("ign_busy_cnt", bc, 32'd3);
    @(posedge clk);
    #1;
    acc(0, 1'b1, 32'h20, 32'h1111_2222, lat, rd, er);
    drive(0, 1'b1, 1'b1, 32'h20, 32'hAAAA_5555);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("mid_busy", {31'b0, b0.busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", {31'b0, b0.ready}, 32'd0);
    check("mid_rst_busy", {31'b0, b0.busy}, 32'd0);
    check("mid_rst_err", {31'b0, b0.err}, 32'd0);
    check("mid_rst_rdata", b0.rdata, 32'h0);
    dsel0 = 8'd8;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("mid_rst_dbg8", dd0, 32'h1111_2222);
    acc(0, 1'b0, 32'h20, 32'h0, lat, rd, er);
    check("post_rst_lat", lat, 32'd3);
    check("post_rst_data", rd, 32'h1111_2222);
    sw = 16'h0F0F;
    acc(1, 1'b1, 32'hFFFF_FF00, 32'h0001_00A5, lat, rd, er);
`ifdef MEM_RESPONDER_MMIO_EN
    check("led_wr_err", {31'b0, er}, 32'd0);
    check("led_val", {16'b0, leds1}, 32'h00A5);
    acc(1, 1'b0, 32'hFFFF_FF04, 32'h0, lat, rd, er);
    check("sw_rd_data", rd, 32'h0000_0F0F);
    check("sw_rd_err", {31'b0, er}, 32'd0);
    acc(1, 1'b0, 32'hFFFF_FF00, 32'h0, lat, rd, er);
    check("led_rd_data", rd, 32'h0000_00A5);
`else
    check("led_wr_err", {31'b0, er}, 32'd1);
    check("led_val", {16'b0, leds1}, 32'h0);
    acc(1, 1'b0, 32'hFFFF_FF04, 32'h0, lat, rd, er);
    check("sw_rd_err", {31'b0, er}, 32'd1);
    check("sw_rd_data", rd, 32'h0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
